counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Programmable interval sequencer wrapped around a 4-bit up-counter datapath. Latches a period and repeat count on `start`, clears and enables the counter, and emits one-cycle `tick` pulses each time the counter reaches the programmed terminal value. It supports one-shot and periodic modes with abort. It sits between the control logic and the 4-bit counter so that the counter is never free-running and its carry output is meaningful per period.

## Interface
- `WIDTH`, 4: counter width; all period/repeat arithmetic is modulo 2^WIDTH.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new sequence; sampled only in IDLE.
- `stop` in 1: abort; sampled in ARM and RUN, and in IDLE as start-veto.
- `mode` in 1: 0 = one-shot, 1 = periodic; latched on accepted start.
- `period` in WIDTH: ticks every `period` cycles; 0 means 2^WIDTH (16); latched on accepted start.
- `reps` in WIDTH: periodic tick limit; 0 = unlimited; latched on accepted start; ignored in one-shot.
- `q` out WIDTH: current counter value.
- `tick` out 1: one-cycle pulse when `q` = terminal (period−1); counter carry equivalent.
- `busy` out 1: high in ARM and RUN.
- `done` out 1: one-cycle pulse on normal completion (not on stop).

## Operation
- Reset: state IDLE; `q`=0, `tick`=0, `busy`=0, `done`=0; latched period/reps/mode and tick counter cleared to 0.
- IDLE: `start`=1 and `stop`=0 → latch inputs, go ARM. `start` and `stop` both high → remain IDLE; stop wins.
- ARM (1 cycle): counter cleared (`q`=0), tick counter cleared; `stop` → IDLE; else → RUN.
- RUN: `q` increments by 1 each cycle. When `q` = period−1 (WIDTH-bit, so period 0 gives terminal 15), `tick`=1 in that cycle and `q` returns to 0 next cycle; the tick counter increments.
  - One-shot: first tick → DONE.
  - Periodic, reps≠0: tick that brings tick count to reps → DONE.
  - Periodic, reps=0: run until stop; tick counter wraps silently.
  - `stop` in RUN → IDLE next cycle. `tick` is still asserted if `q` is terminal in that cycle. No `done`.
- DONE (1 cycle): `done`=1, `busy`=0, `q` holds 0 → IDLE. `start` in DONE is ignored.
- `start` while busy is ignored. Inputs are not re-latched mid-sequence.
- `q` holds its last value in IDLE and DONE, and is 0 after completion.

## Timing
- Start sampled at edge E0 → ARM during cycle 1 → RUN from cycle 2 with `q`=0.
- First `tick` in cycle 2+P−1, where P = period (16 if 0). Subsequent ticks every P cycles.
- `done` in the cycle after the final tick. Back in IDLE the cycle after that, so a new start is accepted one cycle after `done`.
- Stop latency: one edge. `busy` drops in the cycle after `stop` is sampled.
- `rst` overrides everything in the same edge, including mid-RUN: next cycle is IDLE with all outputs 0.
- All outputs are registered or decoded from state/`q` only. No combinational path from inputs to outputs.

## Structure
- Shared package: state encoding (IDLE, ARM, RUN, DONE, 2-bit) and mode constants (ONE_SHOT=0, PERIODIC=1).
- Sub-module `cnt4_core`: WIDTH-bit counter with synchronous `clr` and `en`, outputs `q` and terminal-compare `tc` against the latched terminal value. The controller drives `clr` in ARM and on tick, and `en` in RUN.
- Controller holds the FSM, the latched registers, and the repetition counter.

## Test plan
- One-shot: reset, mode=0, period=5, start at edge 0 → `q` counts 0..4 in cycles 2–6, `tick` in cycle 6, `done` in cycle 7, IDLE in cycle 8, `busy` high in cycles 1–6.
- Periodic limited: mode=1, period=3, reps=4 → ticks in cycles 4, 7, 10, 13; `done` in cycle 14; exactly 4 ticks.
- Wrap: mode=0, period=0 → `q` runs 0..15, `tick` in cycle 17 at `q`=15, `done` in cycle 18.
- Abort and veto: periodic, reps=0, period=4; `stop` at cycle 9 → no `done`, `busy`=0 from cycle 10. In IDLE, `start`=`stop`=1 → stays IDLE.
- Start while busy: second start with period=2 during RUN of period=6 → tick interval remains 6, with no re-latch.
- Reset mid-run: `rst` at cycle 5 of a period=8 run → cycle 6 shows `q`=0, `busy`=0, `tick`=0, `done`=0; a subsequent start behaves as from power-up.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types for the interval sequencer: controller state
// encoding and the one-shot/periodic mode constants.
package counter_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_cnt4_core.sv
// Up-counter datapath with synchronous clear/enable and a
// terminal-count compare against the controller's latched terminal.
module cnt4_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q  = cnt_q;
    assign tc = (cnt_q == term);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Interval sequencer: latches period/reps/mode on start and paces
// the counter core, emitting tick per period and done on completion.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] reps,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] reps_q, reps_d;
    logic [WIDTH-1:0] tcnt_q, tcnt_d;
    logic [WIDTH-1:0] tcnt_inc;
    logic [WIDTH-1:0] term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tc;
    logic             last_tick;

    // Period 0 wraps to an all-ones terminal, i.e. a full 2^WIDTH interval.
    assign term     = period_q - {{(WIDTH-1){1'b0}}, 1'b1};
    assign tcnt_inc = tcnt_q + {{(WIDTH-1){1'b0}}, 1'b1};

    assign last_tick = (mode_q == MODE_ONE_SHOT)
                     || ((reps_q != '0) && (tcnt_inc == reps_q));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        reps_d   = reps_q;
        tcnt_d   = tcnt_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    mode_d   = mode;
                    period_d = period;
                    reps_d   = reps;
                    cnt_clr  = 1'b1;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                cnt_clr = 1'b1;
                tcnt_d  = '0;
                state_d = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                cnt_en = 1'b1;
                if (tc) begin
                    cnt_clr = 1'b1;
                    tcnt_d  = tcnt_inc;
                end
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tc && last_tick) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            period_q <= '0;
            reps_q   <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            reps_q   <= reps_d;
            tcnt_q   <= tcnt_d;
        end
    end

    cnt4_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .term(term),
        .q   (q),
        .tc  (tc)
    );

    assign tick = (state_q == S_RUN) && tc;
    assign busy = (state_q == S_ARM) || (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl: cycle-by-cycle expectations
// derived from the sequencer timing (start at cycle 0, ARM at cycle 1).
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] period;
    logic [3:0] reps;
    logic [3:0] q;
    logic       tick;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(
        .WIDTH(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .period(period),
        .reps  (reps),
        .q     (q),
        .tick  (tick),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_q);
        chk({tag, ".q"}, int'(q), exp_q);
        chk({tag, ".tick"}, int'(tick), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
    endtask

    // Caller is at the negedge of cycle 0. n = number of ticks, p = real
    // period (1..16). Optional re-start attempt at cycle rp_c (0 = none).
    task automatic run_seq(input string tag, input logic m,
                           input logic [3:0] per, input logic [3:0] rp,
                           input int n, input int p, input int rp_c);
        int last;
        int nt;
        int e_busy, e_done, e_tick, e_q;
        last   = n * p + 1;
        nt     = 0;
        mode   = m;
        period = per;
        reps   = rp;
        start  = 1'b1;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rp_c != 0 && c == rp_c) begin
                start  = 1'b1;
                mode   = 1'b0;
                period = 4'd2;
                reps   = 4'd1;
            end
            e_busy = (c >= 1 && c <= last) ? 1 : 0;
            e_done = (c == last + 1) ? 1 : 0;
            e_tick = (c >= 2 && c <= last && ((c - 2) % p) == p - 1) ? 1 : 0;
            chk($sformatf("%s.c%0d.busy", tag, c), int'(busy), e_busy);
            chk($sformatf("%s.c%0d.done", tag, c), int'(done), e_done);
            chk($sformatf("%s.c%0d.tick", tag, c), int'(tick), e_tick);
            if (c >= 2) begin
                e_q = (c <= last) ? (c - 2) % p : 0;
                chk($sformatf("%s.c%0d.q", tag, c), int'(q), e_q);
            end
            if (tick) nt++;
        end
        start = 1'b0;
        chk({tag, ".ntick"}, nt, n);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 1'b0;
        period = 4'd0;
        reps   = 4'd0;
        repeat (3) @(negedge clk);
        chk_idle("rst_hold", 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("rst_rel", 0);

        // one-shot, period 5
        run_seq("oneshot", 1'b0, 4'd5, 4'd0, 1, 5, 0);
        // periodic, period 3, 4 reps
        @(negedge clk);
        run_seq("per3x4", 1'b1, 4'd3, 4'd4, 4, 3, 0);
        // one-shot, period 0 -> 16 cycles, tick at q=15
        @(negedge clk);
        run_seq("wrap", 1'b0, 4'd0, 4'd0, 1, 16, 0);
        // reps ignored in one-shot
        @(negedge clk);
        run_seq("os_reps", 1'b0, 4'd2, 4'd3, 1, 2, 0);
        // start during RUN must not re-latch period 2
        @(negedge clk);
        run_seq("nolatch", 1'b1, 4'd6, 4'd2, 2, 6, 4);

        // start/stop together in IDLE: stop wins
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        mode  = 1'b1;
        period = 4'd4;
        reps   = 4'd0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            chk($sformatf("veto.c%0d.busy", c), int'(busy), 0);
            chk($sformatf("veto.c%0d.done", c), int'(done), 0);
        end

        // periodic unlimited, period 4, stop at cycle 9
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (c == 9);
            chk($sformatf("abort.c%0d.busy", c), int'(busy),
                (c <= 9) ? 1 : 0);
            chk($sformatf("abort.c%0d.done", c), int'(done), 0);
            chk($sformatf("abort.c%0d.tick", c), int'(tick),
                (c == 5 || c == 9) ? 1 : 0);
        end
        stop = 1'b0;

        // reset mid-run of a period-8 one-shot
        mode   = 1'b0;
        period = 4'd8;
        start  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                chk("rstmid.c5.q", int'(q), 3);
                chk("rstmid.c5.busy", int'(busy), 1);
                rst = 1'b1;
            end
            if (c == 6) begin
                rst = 1'b0;
                chk_idle("rstmid.c6", 0);
            end
        end
        run_seq("after_rst", 1'b0, 4'd3, 4'd0, 1, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
